// File: rtl/blit_pixelwrite.sv
// Clips stepper pixels to a rectangle and issues one framebuffer byte write per surviving pixel.
// Two register stages (clip, output): pixel to mem_req in 2 cycles; an unacked request freezes both stages and raises stall.
module blit_pixelwrite #(
    parameter int ADDR_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic [7:0]        in_color,
    input  logic              in_done,
    output logic              stall,
    input  logic [15:0]       clip_x1,
    input  logic [15:0]       clip_y1,
    input  logic [15:0]       clip_x2,
    input  logic [15:0]       clip_y2,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       stride,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              finished,
    output logic              busy
);

    // S1: clip stage
    logic              r_s1_vld;
    logic              r_s1_done;
    logic              r_s1_inside;
    logic [15:0]       r_s1_x;
    logic [15:0]       r_s1_y;
    logic [7:0]        r_s1_color;

    // S2: output stage; r_mem_req doubles as the S2 pixel-valid flag
    logic              r_mem_req;
    logic              r_s2_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_adv;
    logic              w_inside;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_stride_ext;
    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_addr;

    assign w_adv = !r_mem_req || mem_ack;

    // Inclusive signed window; an inverted rectangle fails one pair and rejects all pixels.
    assign w_inside = ($signed(in_x) >= $signed(clip_x1)) && ($signed(in_x) <= $signed(clip_x2)) &&
                      ($signed(in_y) >= $signed(clip_y1)) && ($signed(in_y) <= $signed(clip_y2));

    // Truncating the product to ADDR_W bits is exact modulo 2^ADDR_W, which is all we need.
    assign w_x_ext      = {{(ADDR_W-16){r_s1_x[15]}}, r_s1_x};
    assign w_y_ext      = {{(ADDR_W-16){r_s1_y[15]}}, r_s1_y};
    assign w_stride_ext = {{(ADDR_W-16){1'b0}}, stride};
    assign w_row_off    = w_y_ext * w_stride_ext;
    assign w_addr       = base_addr + w_row_off + w_x_ext;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_vld    <= 1'b0;
            r_s1_done   <= 1'b0;
            r_s1_inside <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_color  <= '0;
        end else if (w_adv) begin
            r_s1_done   <= in_done;
            r_s1_vld    <= in_valid && !in_done;
            r_s1_inside <= w_inside;
            r_s1_x      <= in_x;
            r_s1_y      <= in_y;
            r_s1_color  <= in_color;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_s2_done   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_adv) begin
            r_mem_req <= r_s1_vld && r_s1_inside;
            r_s2_done <= r_s1_done;
            if (r_s1_vld && r_s1_inside) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= r_s1_color;
            end
        end
    end

    assign stall     = !w_adv;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    // A done token never carries a request, so this is a clean one-cycle pulse.
    assign finished  = r_s2_done && !r_mem_req;
    assign busy      = r_s1_vld || r_s1_done || r_mem_req || r_s2_done;

endmodule

// File: doc/blit_pixelwrite.md
# blit_pixelwrite

Consumer end of the blitter coordinate stream. It takes the per-cycle (x, y) pixel positions from the line stepper and clips each one against a rectangle. For pixels that survive, it computes the framebuffer byte address and issues one memory write request per pixel, using a valid/ack handshake. When the memory side holds off, it back-pressures the stepper through `stall`.

## Interface

Parameters:
- ADDR_W, 26, width of framebuffer byte address; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  a pixel coordinate is presented this cycle
- in_x  in  16  pixel x, signed
- in_y  in  16  pixel y, signed
- in_color  in  8  pixel value to write
- in_done  in  1  end-of-primitive marker; carries no pixel
- stall  out  1  producer must hold its inputs and not advance this cycle
- clip_x1, clip_y1, clip_x2, clip_y2  in  16 each  inclusive clip rectangle, signed; must be stable while busy
- base_addr  in  ADDR_W  framebuffer base byte address; must be stable while busy
- stride  in  16  bytes per row, unsigned; must be stable while busy
- mem_req  out  1  write request valid
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  8  write data
- mem_ack  in  1  request accepted this cycle
- finished  out  1  one-cycle pulse: all pixels of the primitive have been acked
- busy  out  1  any stage holds a pixel or a done token

## Operation

- Pipeline has two register stages, S1 (clip) and S2 (output).
  - Each stage holds `valid`, `done`, and its payload.
- Advance condition: `adv = !mem_req || mem_ack`.
  - `stall = !adv`, combinational from the registered `mem_req` and the `mem_ack` input.
- Input capture on `adv`:
  - If `in_done`, S1 takes a done token; any pixel presented in the same cycle is discarded.
  - Else if `in_valid`, S1 takes a pixel with `inside` computed.
  - Else S1 is loaded empty.
- Clip rule:
  - `inside = (clip_x1 <= x <= clip_x2) && (clip_y1 <= y <= clip_y2)`, signed 16-bit compares, inclusive.
  - An empty rectangle (x1 > x2 or y1 > y2) rejects every pixel.
- S1 to S2 on `adv`:
  - A pixel with `inside = 1` loads S2 with `mem_req = 1`, `mem_addr = base_addr + y*stride + x`, and `mem_wdata = color`.
  - A clipped pixel loads S2 empty, so no request is issued.
  - A done token loads S2 with `done = 1` and `mem_req = 0`.
- Address arithmetic:
  - y and x are sign-extended to ADDR_W, and y*stride is formed at full width.
  - The sum is truncated to ADDR_W bits, wrapping mod 2^ADDR_W.
- Request rule:
  - `mem_req`, `mem_addr` and `mem_wdata` stay constant while `mem_req = 1 && !mem_ack`.
  - Exactly one write is issued per inside pixel, in input order.
- Completion:
  - `finished = S2.done && !mem_req`.
  - Because `adv = 1` in that cycle, S2 reloads on the next edge, so `finished` lasts exactly one cycle.
  - Every pixel accepted before `in_done` has been acked before `finished` rises.
- `busy = S1.valid || S1.done || S2.valid || S2.done`.

## Timing

- Reset values: `mem_req = 0`, `mem_addr = 0`, `mem_wdata = 0`, `finished = 0`, `busy = 0`, `stall = 0`; both stages are empty.
- Latency: a pixel accepted at the edge ending cycle N (`adv = 1`) drives `mem_req = 1` in cycle N+2.
  - This assumes `adv` was 1 in cycle N+1.
- With `mem_ack` tied high, throughput is one pixel per cycle and `stall` stays 0.
- `mem_ack` while `mem_req = 0` is ignored.
- `stall` rises in the same cycle as any unacked `mem_req`. The producer's registers must not update during that cycle.
- Done token: `in_done` accepted in cycle N gives `finished` in cycle N+2 if nothing is pending ahead of it. Otherwise `finished` comes later, after the last ack.
- Reset mid-operation: any outstanding request is abandoned, and `mem_req = 0` from the cycle after the reset edge.
  - Tokens are discarded and `finished` is not pulsed for the aborted primitive.
- Back-to-back primitives are allowed: a new pixel may be accepted in the same cycle that `finished` is high.

## Test plan

- Ack tied high; clip (0,0)-(99,99); base 0x1000; stride 320; pixels (3,2),(4,2),(5,3) then done.
  - Expect writes to 0x1283, 0x1284, 0x13C5 in cycles N+2..N+4.
  - `finished` pulses once, one cycle after the last write; `stall` is never high.
- Clip (10,10)-(20,20); pixels (9,10),(10,10),(20,20),(21,15),(-1,12).
  - Expect exactly two writes, for (10,10) and (20,20); the other three produce no `mem_req`.
- Ack held low for 3 cycles on the first request of a 4-pixel burst.
  - `stall` is high those 3 cycles, `mem_addr`/`mem_wdata` are stable, no pixel is lost or duplicated, and order is preserved.
- Done token with all pixels clipped (empty rectangle x1 = 5, x2 = 4).
  - No `mem_req`; `finished` pulses 2 cycles after `in_done`.
- Reset asserted while `mem_req` is pending and S1 is holding a pixel.
  - `mem_req = 0`, `busy = 0` and `stall = 0` next cycle; no `finished` pulse.
  - A following primitive writes correctly.
- Wrap-around: base 0x3FFFFFF, stride 1, pixel (1,0).
  - `mem_addr = 0x0000000`.
